// File: rtl/painterengine_gpu_dma_reader.sv
// AXI4 read master for the display streamer: fetches a word run as 4 KB-safe INCR bursts
// and forwards it one word per strobe, reporting done or error for each request.
module painterengine_gpu_dma_reader #(
  parameter int MAX_BURST  = 16,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  i_wire_clock,
  input  logic                  i_wire_resetn,
  input  logic                  i_wire_reader_resetn,
  input  logic [ADDR_WIDTH-1:0] i_wire_reader_address,
  input  logic [31:0]           i_wire_reader_length,
  output logic                  o_wire_reader_done,
  output logic                  o_wire_reader_error,
  output logic [31:0]           o_wire_reader_data,
  output logic                  o_wire_reader_data_valid,
  input  logic                  i_wire_reader_data_next,
  output logic [ADDR_WIDTH-1:0] o_wire_araddr,
  output logic [7:0]            o_wire_arlen,
  output logic [2:0]            o_wire_arsize,
  output logic [1:0]            o_wire_arburst,
  output logic                  o_wire_arvalid,
  input  logic                  i_wire_arready,
  input  logic [31:0]           i_wire_rdata,
  input  logic [1:0]            i_wire_rresp,
  input  logic                  i_wire_rlast,
  input  logic                  i_wire_rvalid,
  output logic                  o_wire_rready
);

  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_DATA, S_DRAIN, S_DONE, S_ERROR} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]           remaining_q, remaining_d;
  logic [ADDR_WIDTH-1:0] araddr_q, araddr_d;
  logic [7:0]            arlen_q, arlen_d;
  logic                  arvalid_q, arvalid_d;
  logic [7:0]            beat_q, beat_d;
  logic                  err_q, err_d;
  logic                  open_q, open_d;

  logic        issue;
  logic        rready;
  logic        data_valid;
  logic        r_hs;
  logic        beat_ok;
  logic [10:0] page_words;
  logic [31:0] beats;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    remaining_d = remaining_q;
    araddr_d    = araddr_q;
    arlen_d     = arlen_q;
    arvalid_d   = arvalid_q;
    beat_d      = beat_q;
    err_d       = err_q;
    open_d      = open_q;
    issue       = 1'b0;
    rready      = 1'b0;
    data_valid  = 1'b0;
    r_hs        = 1'b0;
    page_words  = '0;
    beats       = '0;
    // A beat is good only with OKAY response and rlast exactly on the final beat.
    beat_ok     = (i_wire_rresp == 2'b00) && (i_wire_rlast == (beat_q == arlen_q));

    case (state_q)
      S_IDLE: begin
        err_d  = 1'b0;
        open_d = 1'b0;
        if (i_wire_reader_resetn) begin
          addr_d      = i_wire_reader_address;
          remaining_d = i_wire_reader_length;
          if (i_wire_reader_length == 32'd0) begin
            state_d = S_DONE;
          end else if (i_wire_reader_address[1:0] != 2'b00) begin
            state_d = S_ERROR;
          end else begin
            state_d = S_ADDR;
            issue   = 1'b1;
          end
        end
      end
      S_ADDR: begin
        if (i_wire_arready) arvalid_d = 1'b0;
        if (!i_wire_reader_resetn) begin
          state_d = S_DRAIN;
          err_d   = 1'b0;
          open_d  = 1'b1;
        end else if (i_wire_arready) begin
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        // On abort, swallow instead of forwarding so the burst can still complete.
        rready = !i_wire_reader_resetn || i_wire_reader_data_next;
        r_hs   = i_wire_rvalid && rready;
        if (!i_wire_reader_resetn) begin
          state_d = S_DRAIN;
          err_d   = 1'b0;
          open_d  = !(r_hs && i_wire_rlast);
        end else if (r_hs) begin
          if (!beat_ok) begin
            state_d = S_DRAIN;
            err_d   = 1'b1;
            open_d  = !i_wire_rlast;
          end else begin
            data_valid  = 1'b1;
            addr_d      = addr_q + ADDR_WIDTH'(4);
            remaining_d = remaining_q - 32'd1;
            beat_d      = beat_q + 8'd1;
            if (beat_q == arlen_q) begin
              if (remaining_q == 32'd1) begin
                state_d = S_DONE;
              end else begin
                state_d = S_ADDR;
                issue   = 1'b1;
              end
            end
          end
        end
      end
      S_DRAIN: begin
        rready = 1'b1;
        if (arvalid_q && i_wire_arready) arvalid_d = 1'b0;
        if (i_wire_rvalid && i_wire_rlast) open_d = 1'b0;
        if (!open_q && !arvalid_q) state_d = err_q ? S_ERROR : S_IDLE;
      end
      S_DONE, S_ERROR: begin
        if (!i_wire_reader_resetn) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Burst length is capped by what is left, MAX_BURST, and the words left in this 4 KB page.
    if (issue) begin
      page_words = 11'((13'h1000 - {1'b0, addr_d[11:0]}) >> 2);
      beats      = remaining_d;
      if (beats > 32'(MAX_BURST)) beats = 32'(MAX_BURST);
      if (beats > {21'd0, page_words}) beats = {21'd0, page_words};
      araddr_d  = addr_d;
      arlen_d   = 8'(beats - 32'd1);
      arvalid_d = 1'b1;
      beat_d    = 8'd0;
    end
  end

  always_ff @(posedge i_wire_clock or negedge i_wire_resetn) begin
    if (!i_wire_resetn) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      remaining_q <= '0;
      araddr_q    <= '0;
      arlen_q     <= '0;
      arvalid_q   <= 1'b0;
      beat_q      <= '0;
      err_q       <= 1'b0;
      open_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      remaining_q <= remaining_d;
      araddr_q    <= araddr_d;
      arlen_q     <= arlen_d;
      arvalid_q   <= arvalid_d;
      beat_q      <= beat_d;
      err_q       <= err_d;
      open_q      <= open_d;
    end
  end

  assign o_wire_reader_done       = (state_q == S_DONE);
  assign o_wire_reader_error      = (state_q == S_ERROR);
  assign o_wire_reader_data       = i_wire_rdata;
  assign o_wire_reader_data_valid = data_valid;
  assign o_wire_araddr            = araddr_q;
  assign o_wire_arlen             = arlen_q;
  assign o_wire_arsize            = 3'b010;
  assign o_wire_arburst           = 2'b01;
  assign o_wire_arvalid           = arvalid_q;
  assign o_wire_rready            = rready;

endmodule

// File: tb/tb_painterengine_gpu_dma_reader.sv
// Bench for painterengine_gpu_dma_reader: AXI slave model plus scoreboards of expected
// AR bursts and stream words, one task per scenario.
module tb_painterengine_gpu_dma_reader;

  logic        clk = 1'b0;
  logic        resetn;
  logic        reader_resetn;
  logic [31:0] reader_address;
  logic [31:0] reader_length;
  logic        done_o, error_o;
  logic [31:0] data_o;
  logic        data_valid_o;
  logic        data_next;
  logic [31:0] araddr_o;
  logic [7:0]  arlen_o;
  logic [2:0]  arsize_o;
  logic [1:0]  arburst_o;
  logic        arvalid_o;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready_o;

  always #5 clk = ~clk;

  painterengine_gpu_dma_reader #(.MAX_BURST(16), .ADDR_WIDTH(32)) dut (
    .i_wire_clock(clk),
    .i_wire_resetn(resetn),
    .i_wire_reader_resetn(reader_resetn),
    .i_wire_reader_address(reader_address),
    .i_wire_reader_length(reader_length),
    .o_wire_reader_done(done_o),
    .o_wire_reader_error(error_o),
    .o_wire_reader_data(data_o),
    .o_wire_reader_data_valid(data_valid_o),
    .i_wire_reader_data_next(data_next),
    .o_wire_araddr(araddr_o),
    .o_wire_arlen(arlen_o),
    .o_wire_arsize(arsize_o),
    .o_wire_arburst(arburst_o),
    .o_wire_arvalid(arvalid_o),
    .i_wire_arready(arready),
    .i_wire_rdata(rdata),
    .i_wire_rresp(rresp),
    .i_wire_rlast(rlast),
    .i_wire_rvalid(rvalid),
    .o_wire_rready(rready_o)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [31:0] exp_data[$];
  logic [39:0] exp_ar[$];
  logic [39:0] slv_q[$];

  bit          slv_active = 0;
  logic [31:0] slv_addr;
  int          slv_beat, slv_len, slv_gbeat;
  int          strobes, ar_count, last_strobe_cyc, done_cyc;
  bit          arready_en = 1;
  bit          dn_toggle = 0;
  bit          chk_rready = 0;
  int          err_beat = 0;
  logic        done_s, err_s;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1234_0000;
  endfunction

  task automatic new_test();
    strobes = 0; ar_count = 0; last_strobe_cyc = -100; done_cyc = -1;
    slv_gbeat = 0; err_beat = 0; arready_en = 1; dn_toggle = 0; chk_rready = 0;
    done_s = 0; err_s = 0;
  endtask

  task automatic push_words(input logic [31:0] a, input int n);
    for (int i = 0; i < n; i++) exp_data.push_back(mem(a + 32'(4 * i)));
  endtask

  // One clock cycle: drive slave/consumer inputs, sample at negedge, advance model after posedge.
  task automatic cycle();
    bit ar_hs, r_hs;
    logic [39:0] e;
    logic [31:0] w;
    if (!slv_active && slv_q.size() > 0) begin
      e = slv_q.pop_front();
      slv_addr = e[39:8]; slv_len = int'(e[7:0]) + 1; slv_beat = 1; slv_active = 1;
    end
    arready   = arready_en;
    data_next = dn_toggle ? cyc[0] : 1'b1;
    rvalid    = slv_active;
    rdata     = slv_active ? mem(slv_addr) : 32'h0;
    rlast     = slv_active && (slv_beat == slv_len);
    rresp     = (slv_active && (slv_gbeat + 1 == err_beat)) ? 2'b10 : 2'b00;
    @(negedge clk);
    ar_hs = arvalid_o && arready;
    r_hs  = rvalid && rready_o;
    if (!data_next) begin
      checks++;
      if (data_valid_o !== 1'b0) begin
        errors++; $display("FAIL dv_without_next cyc=%0d data_valid=%b required 0", cyc, data_valid_o);
      end
    end
    if (chk_rready && rvalid) begin
      checks++;
      if (rready_o !== data_next) begin
        errors++; $display("FAIL rready_tracks cyc=%0d rready=%b required %b", cyc, rready_o, data_next);
      end
    end
    if (data_valid_o === 1'b1) begin
      strobes++; last_strobe_cyc = cyc; checks++;
      if (exp_data.size() == 0) begin
        errors++; $display("FAIL unexpected_word cyc=%0d data=%h required none", cyc, data_o);
      end else begin
        w = exp_data.pop_front();
        if (data_o !== w) begin
          errors++; $display("FAIL data_word cyc=%0d data=%h required %h", cyc, data_o, w);
        end
      end
    end
    if (ar_hs) begin
      ar_count++; checks++;
      if (exp_ar.size() == 0) begin
        errors++; $display("FAIL unexpected_ar cyc=%0d araddr=%h arlen=%0d required none", cyc, araddr_o, arlen_o);
      end else begin
        e = exp_ar.pop_front();
        if ({araddr_o, arlen_o} !== e) begin
          errors++; $display("FAIL ar_burst cyc=%0d araddr=%h arlen=%0d required %h/%0d", cyc, araddr_o, arlen_o, e[39:8], e[7:0]);
        end
      end
      slv_q.push_back({araddr_o, arlen_o});
    end
    done_s = done_o; err_s = error_o;
    if (done_o === 1'b1 && done_cyc < 0) done_cyc = cyc;
    @(posedge clk); #1;
    if (r_hs) begin
      slv_gbeat++; slv_addr += 32'd4;
      if (slv_beat == slv_len) slv_active = 0; else slv_beat++;
    end
    cyc++;
  endtask

  task automatic run_request(input logic [31:0] a, input logic [31:0] n, input int budget, output int iters);
    reader_address = a; reader_length = n; reader_resetn = 1'b1;
    iters = 0;
    for (int i = 0; i < budget; i++) begin
      cycle();
      iters = i + 1;
      if (done_s || err_s) break;
    end
    if (!(done_s || err_s)) begin
      checks++; errors++;
      $display("FAIL timeout addr=%h len=%0d done=%b error=%b required completion", a, n, done_s, err_s);
    end
    $display("request addr=%h len=%0d iters=%0d strobes=%0d ars=%0d done=%b error=%b", a, n, iters, strobes, ar_count, done_s, err_s);
  endtask

  task automatic finish_request(input string name);
    reader_resetn = 1'b0;
    cycle(); cycle();
    checks++;
    if (done_s !== 1'b0 || err_s !== 1'b0) begin
      errors++; $display("FAIL %s_status_clear done=%b error=%b required 0/0", name, done_s, err_s);
    end
    checks++;
    if (exp_data.size() != 0 || exp_ar.size() != 0) begin
      errors++; $display("FAIL %s_leftover words=%0d ars=%0d required 0/0", name, exp_data.size(), exp_ar.size());
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0; reader_resetn = 1'b0; reader_address = '0; reader_length = '0;
    data_next = 1'b1; arready = 1'b1; rvalid = 1'b0; rdata = '0; rresp = '0; rlast = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (arvalid_o !== 1'b0) begin errors++; $display("FAIL reset_arvalid got %b required 0", arvalid_o); end
    checks++; if (rready_o !== 1'b0) begin errors++; $display("FAIL reset_rready got %b required 0", rready_o); end
    checks++; if (done_o !== 1'b0 || error_o !== 1'b0) begin errors++; $display("FAIL reset_status got %b/%b required 0/0", done_o, error_o); end
    checks++; if (data_valid_o !== 1'b0) begin errors++; $display("FAIL reset_data_valid got %b required 0", data_valid_o); end
    checks++; if (araddr_o !== 32'h0 || arlen_o !== 8'h0) begin errors++; $display("FAIL reset_ar got %h/%0d required 0/0", araddr_o, arlen_o); end
    checks++; if (arsize_o !== 3'b010 || arburst_o !== 2'b01) begin errors++; $display("FAIL ar_const got %b/%b required 010/01", arsize_o, arburst_o); end
    @(posedge clk); #1;
    resetn = 1'b1;
  endtask

  task automatic test_bursts_48();
    int iters;
    new_test();
    for (int i = 0; i < 3; i++) exp_ar.push_back({32'h1000_0000 + 32'(64 * i), 8'd15});
    push_words(32'h1000_0000, 48);
    run_request(32'h1000_0000, 32'd48, 300, iters);
    checks++; if (strobes != 48) begin errors++; $display("FAIL b48_strobes got %0d required 48", strobes); end
    checks++; if (ar_count != 3) begin errors++; $display("FAIL b48_ars got %0d required 3", ar_count); end
    checks++; if (done_s !== 1'b1 || err_s !== 1'b0) begin errors++; $display("FAIL b48_status got %b/%b required 1/0", done_s, err_s); end
    checks++; if (done_cyc - last_strobe_cyc != 1) begin errors++; $display("FAIL b48_done_latency got %0d required 1", done_cyc - last_strobe_cyc); end
    finish_request("b48");
  endtask

  task automatic test_page_cross();
    int iters;
    new_test();
    exp_ar.push_back({32'h0000_0FF0, 8'd3});
    exp_ar.push_back({32'h0000_1000, 8'd3});
    push_words(32'h0000_0FF0, 8);
    run_request(32'h0000_0FF0, 32'd8, 100, iters);
    checks++; if (strobes != 8 || ar_count != 2) begin errors++; $display("FAIL page_counts got %0d/%0d required 8/2", strobes, ar_count); end
    checks++; if (done_s !== 1'b1) begin errors++; $display("FAIL page_done got %b required 1", done_s); end
    finish_request("page");
  endtask

  task automatic test_backpressure();
    int iters;
    new_test();
    dn_toggle = 1; chk_rready = 1;
    for (int i = 0; i < 3; i++) exp_ar.push_back({32'h2000_0000 + 32'(64 * i), 8'd15});
    push_words(32'h2000_0000, 48);
    run_request(32'h2000_0000, 32'd48, 400, iters);
    checks++; if (strobes != 48) begin errors++; $display("FAIL bp_strobes got %0d required 48", strobes); end
    checks++; if (done_s !== 1'b1) begin errors++; $display("FAIL bp_done got %b required 1", done_s); end
    chk_rready = 0; dn_toggle = 0;
    finish_request("bp");
  endtask

  task automatic test_slverr();
    int iters;
    new_test();
    err_beat = 5;
    exp_ar.push_back({32'h3000_0000, 8'd15});
    push_words(32'h3000_0000, 4);
    run_request(32'h3000_0000, 32'd32, 100, iters);
    checks++; if (err_s !== 1'b1 || done_s !== 1'b0) begin errors++; $display("FAIL err_status got done=%b error=%b required 0/1", done_s, err_s); end
    checks++; if (strobes != 4) begin errors++; $display("FAIL err_strobes got %0d required 4", strobes); end
    checks++; if (slv_gbeat != 16 || slv_active) begin errors++; $display("FAIL err_drain beats=%0d active=%b required 16/0", slv_gbeat, slv_active); end
    repeat (6) cycle();
    checks++; if (ar_count != 1 || err_s !== 1'b1) begin errors++; $display("FAIL err_hold ars=%0d error=%b required 1/1", ar_count, err_s); end
    err_beat = 0;
    finish_request("err");
  endtask

  task automatic test_degenerate();
    int iters;
    new_test();
    run_request(32'h1000_0000, 32'd0, 10, iters);
    checks++; if (done_s !== 1'b1 || iters != 2) begin errors++; $display("FAIL zero_len done=%b iters=%0d required 1/2", done_s, iters); end
    checks++; if (ar_count != 0) begin errors++; $display("FAIL zero_len_ar got %0d required 0", ar_count); end
    finish_request("zero");
    new_test();
    run_request(32'h1000_0002, 32'd4, 10, iters);
    checks++; if (err_s !== 1'b1 || done_s !== 1'b0 || iters != 2) begin errors++; $display("FAIL misalign error=%b done=%b iters=%0d required 1/0/2", err_s, done_s, iters); end
    checks++; if (ar_count != 0) begin errors++; $display("FAIL misalign_ar got %0d required 0", ar_count); end
    finish_request("misalign");
  endtask

  task automatic test_abort();
    new_test();
    arready_en = 0;
    exp_ar.push_back({32'h4000_0000, 8'd15});
    reader_address = 32'h4000_0000; reader_length = 32'd16; reader_resetn = 1'b1;
    repeat (4) cycle();
    checks++; if (arvalid_o !== 1'b1) begin errors++; $display("FAIL abort_ar_pending arvalid=%b required 1", arvalid_o); end
    reader_resetn = 1'b0; arready_en = 1;
    repeat (30) cycle();
    checks++; if (ar_count != 1 || slv_gbeat != 16 || slv_active) begin errors++; $display("FAIL abort_ar_drain ars=%0d beats=%0d required 1/16", ar_count, slv_gbeat); end
    checks++; if (strobes != 0 || done_s !== 1'b0 || err_s !== 1'b0) begin errors++; $display("FAIL abort_ar_quiet strobes=%0d done=%b error=%b required 0/0/0", strobes, done_s, err_s); end
    $display("abort while arvalid pending: ars=%0d drained=%0d", ar_count, slv_gbeat);
    finish_request("abort_ar");

    new_test();
    exp_ar.push_back({32'h5000_0000, 8'd15});
    push_words(32'h5000_0000, 5);
    reader_address = 32'h5000_0000; reader_length = 32'd32; reader_resetn = 1'b1;
    for (int i = 0; i < 50 && strobes < 5; i++) cycle();
    reader_resetn = 1'b0;
    repeat (30) cycle();
    checks++; if (strobes != 5) begin errors++; $display("FAIL abort_mid_strobes got %0d required 5", strobes); end
    checks++; if (ar_count != 1 || slv_gbeat != 16 || slv_active) begin errors++; $display("FAIL abort_mid_drain ars=%0d beats=%0d required 1/16", ar_count, slv_gbeat); end
    $display("abort mid-burst: strobes=%0d drained=%0d", strobes, slv_gbeat);
    finish_request("abort_mid");
  endtask

  task automatic test_back_to_back();
    int iters;
    new_test();
    exp_ar.push_back({32'h6000_0FC0, 8'd15});
    exp_ar.push_back({32'h6000_1000, 8'd3});
    push_words(32'h6000_0FC0, 20);
    run_request(32'h6000_0FC0, 32'd20, 200, iters);
    checks++; if (strobes != 20 || done_s !== 1'b1) begin errors++; $display("FAIL b2b_run strobes=%0d done=%b required 20/1", strobes, done_s); end
    finish_request("b2b");
  endtask

  initial begin
    test_reset();
    test_bursts_48();
    test_page_cross();
    test_backpressure();
    test_slverr();
    test_degenerate();
    test_abort();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
